posttu_stream: RTL and testbench
================================

Name: posttu_stream

Overview:
- Winograd F(2x2,3x3) output (inverse) transform: Y = Aᵀ·M·A, with Aᵀ = [[1,1,1,0],[0,1,-1,-1]].
- Converts each 4x4 element-wise-product tile M into a 2x2 spatial output tile.
- Sits downstream of the pre-transform/EWMM stage and consumes M one row per beat over a valid/ready stream.
- Row transform is applied per beat. The column transform runs when the 4th row is accepted, and the result is held in an output register.

Parameters:
- DW, 16, signed width of each M element.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset: asynchronous assertion, active-low (one clock domain, no other clocks).
- clr  in  1  synchronous soft clear; discards the partial tile and any pending output.
- in_valid  in  1  row beat valid.
- in_ready  out  1  row beat accepted when in_valid && in_ready.
- in_row  in  4*DW  one row of M: element k = in_row[k*DW +: DW], signed; rows arrive in order 0..3.
- out_valid  out  1  output tile valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_tile  out  4*(DW+4)  {Y11,Y10,Y01,Y00}: Y00 at [0 +: DW+4], Y01 next, Y10 next, Y11 at the top; all signed.
- row_idx  out  2  index of the next row to be accepted.
- busy  out  1  high when row_idx != 0 or out_valid.

Behaviour:
- Reset (rst_n low, async): row_idx=0, out_valid=0, out_tile=0, row buffer=0, busy=0. in_ready follows its equation, so it is 1 after reset.
- Row transform on each accepted beat, full sign extension to DW+2:
  - t[r][0] = m0+m1+m2
  - t[r][1] = m1-m2-m3
  - stored into row buffer slot r = row_idx; row_idx increments mod 4.
- Column transform is combinational from buffer rows 0..2 plus the live row-3 result (DW+4 wide, sign-extended). For c in {0,1}:
  - Y0c = t0c+t1c+t2c
  - Y1c = t1c-t2c-t3c
- Capture: out_tile is registered on the cycle the row-3 beat is accepted. out_valid rises the next cycle, giving latency 1 clk from the 4th beat.
- Arithmetic: no saturation or rounding. DW+4 is provably sufficient (|Y| ≤ 9·2^(DW-1)).
- Handshake and backpressure:
  - in_ready = !(row_idx==3 && out_valid && !out_ready).
  - Rows 0..2 of the next tile are always accepted while an output is stalled.
  - in_ready does not depend on in_valid.
- Simultaneous row-3 accept and output handshake in the same cycle: the new tile overwrites out_tile and out_valid stays 1. Full throughput is 1 tile per 4 cycles with no bubbles.
- Output hold: out_valid stays 1 and out_tile stays stable until out_ready. out_valid clears on a handshake unless a new tile is captured in that cycle.
- No beat accepted means no state change: row buffer and row_idx hold, even with in_row toggling.
- clr (sync):
  - row_idx<=0, out_valid<=0; a beat presented in the same cycle is dropped.
  - Row buffer contents are don't-care (overwritten before use).
  - clr has priority over all other updates.
- Reset mid-tile: partial rows are discarded; the first beat after reset is row 0.

Test Plan:
- All M elements = 1, 4 back-to-back beats, out_ready=1 -> one cycle after the 4th beat out_valid=1 with Y00=9, Y01=-3, Y10=-3, Y11=1; in_ready never drops.
- Only m[1][1]=5, rest 0 -> Y00=Y01=Y10=Y11=5; row_idx sequence 0,1,2,3,0.
- DW=16, all elements = -32768 -> Y00=-294912, Y01=98304, Y10=98304, Y11=-32768; no overflow in 20-bit fields.
- Stall: hold out_ready=0 after tile A, stream tile B -> B rows 0..2 accepted. in_ready=0 at row_idx=3 until out_ready=1. out_tile holds A, then B is captured in the handshake cycle and out_valid stays 1.
- Continuous 8 tiles with random in_valid gaps and random out_ready -> every tile matches the golden Aᵀ·M·A model in order, with no loss or duplication.
- Assert clr (and separately rst_n) after 2 rows with a stalled output -> out_valid=0, row_idx=0. The next 4 beats form a fresh tile with the correct result.

Source files
------------

// File: rtl/posttu_stream.sv
// Winograd F(2x2,3x3) inverse transform: consumes a 4x4 M tile one row per beat
// and emits the 2x2 tile Y = At*M*A, registered on acceptance of the last row.
module posttu_stream #(
  parameter int DW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DW-1:0]     in_row,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*(DW+4)-1:0] out_tile,
  output logic [1:0]          row_idx,
  output logic                busy
);

  localparam int TW = DW + 2;
  localparam int YW = DW + 4;

  logic [1:0]          row_idx_reg;
  logic                out_valid_reg;
  logic [4*YW-1:0]     out_tile_reg;
  logic [4*YW-1:0]     tile_next;
  logic signed [TW-1:0] buf_t0_reg [0:2];
  logic signed [TW-1:0] buf_t1_reg [0:2];
  logic signed [TW-1:0] m_ext [0:3];
  logic signed [TW-1:0] row_t0;
  logic signed [TW-1:0] row_t1;
  logic signed [YW-1:0] tcol [0:1][0:3];
  logic signed [YW-1:0] y0 [0:1];
  logic signed [YW-1:0] y1 [0:1];
  logic                accept;
  logic                last_row;
  logic                capture;

  // Only the last row can be refused, and only while the held tile is stalled.
  assign in_ready = !(row_idx_reg == 2'd3 && out_valid_reg && !out_ready);
  assign accept   = in_valid && in_ready;
  assign last_row = (row_idx_reg == 2'd3);
  assign capture  = accept && last_row;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ext
      assign m_ext[gi] = TW'($signed(in_row[gi*DW +: DW]));
    end
  endgenerate

  assign row_t0 = m_ext[0] + m_ext[1] + m_ext[2];
  assign row_t1 = m_ext[1] - m_ext[2] - m_ext[3];

  // Rows 0..2 come from the buffer; row 3 is the live beat, never stored.
  generate
    for (gi = 0; gi < 3; gi++) begin : g_col_rows
      assign tcol[0][gi] = YW'(buf_t0_reg[gi]);
      assign tcol[1][gi] = YW'(buf_t1_reg[gi]);
    end
  endgenerate
  assign tcol[0][3] = YW'(row_t0);
  assign tcol[1][3] = YW'(row_t1);

  generate
    for (gi = 0; gi < 2; gi++) begin : g_col
      assign y0[gi] = tcol[gi][0] + tcol[gi][1] + tcol[gi][2];
      assign y1[gi] = tcol[gi][1] - tcol[gi][2] - tcol[gi][3];
    end
  endgenerate

  assign tile_next = {y1[1], y1[0], y0[1], y0[0]};

  generate
    for (gi = 0; gi < 3; gi++) begin : g_buf
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          buf_t0_reg[gi] <= '0;
          buf_t1_reg[gi] <= '0;
        end else if (!clr && accept && row_idx_reg == 2'(gi)) begin
          buf_t0_reg[gi] <= row_t0;
          buf_t1_reg[gi] <= row_t1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_idx_reg   <= 2'd0;
      out_valid_reg <= 1'b0;
      out_tile_reg  <= '0;
    end else if (clr) begin
      row_idx_reg   <= 2'd0;
      out_valid_reg <= 1'b0;
    end else begin
      if (accept) begin
        row_idx_reg <= row_idx_reg + 2'd1;
      end
      // A capture in the handshake cycle replaces the tile and keeps valid high.
      if (capture) begin
        out_tile_reg  <= tile_next;
        out_valid_reg <= 1'b1;
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_tile  = out_tile_reg;
  assign row_idx   = row_idx_reg;
  assign busy      = (row_idx_reg != 2'd0) || out_valid_reg;

endmodule

// File: tb/tb_posttu_stream.sv
// Directed and scoreboarded checks of the Winograd output transform stream.
module tb_posttu_stream;

  localparam int DW = 16;
  localparam int YW = DW + 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [4*DW-1:0]   in_row;
  logic              out_valid;
  logic              out_ready;
  logic [4*YW-1:0]   out_tile;
  logic [1:0]        row_idx;
  logic              busy;

  posttu_stream #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tile  (out_tile),
    .row_idx   (row_idx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int mtx [4][4];
  int rt [8][4][4];
  logic [4*YW-1:0] exp_q [$];

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint yf(input logic [4*YW-1:0] t, input int k);
    return longint'($signed(t[k*YW +: YW]));
  endfunction

  function automatic logic [4*DW-1:0] rowpack(input int r);
    logic [4*DW-1:0] v;
    for (int k = 0; k < 4; k++) v[k*DW +: DW] = 16'(mtx[r][k]);
    return v;
  endfunction

  function automatic logic [4*DW-1:0] rowpack_rt(input int t, input int r);
    logic [4*DW-1:0] v;
    for (int k = 0; k < 4; k++) v[k*DW +: DW] = 16'(rt[t][r][k]);
    return v;
  endfunction

  function automatic int at(input int i, input int k);
    if (i == 0) return (k < 3) ? 1 : 0;
    return (k == 0) ? 0 : ((k == 1) ? 1 : -1);
  endfunction

  // Straight matrix product At*M*A, independent of the row/column split.
  function automatic logic [4*YW-1:0] golden(input int t);
    logic [4*YW-1:0] y;
    longint s;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        s = 0;
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            s += longint'(at(i, r)) * longint'(rt[t][r][c]) * longint'(at(j, c));
        y[(2*i+j)*YW +: YW] = YW'(s);
      end
    return y;
  endfunction

  task automatic fill(input int val);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) mtx[r][c] = val;
  endtask

  // Called at a negedge; drives one cycle and returns at the next negedge.
  task automatic step(input logic v, input logic [4*DW-1:0] r, input logic ordy,
                      output logic acc);
    in_valid  = v;
    in_row    = r;
    out_ready = ordy;
    #1;
    acc = v && in_ready;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_rows(input string tag, input int first, input int last,
                          input logic ordy);
    logic acc;
    for (int r = first; r <= last; r++) begin
      chk({tag, "_rowidx"}, row_idx, r);
      step(1'b1, rowpack(r), ordy, acc);
      chk({tag, "_acc"}, acc, 1);
    end
  endtask

  task automatic check_y(input string tag, input longint e00, input longint e01,
                         input longint e10, input longint e11);
    chk({tag, "_y00"}, yf(out_tile, 0), e00);
    chk({tag, "_y01"}, yf(out_tile, 1), e01);
    chk({tag, "_y10"}, yf(out_tile, 2), e10);
    chk({tag, "_y11"}, yf(out_tile, 3), e11);
  endtask

  initial begin
    logic acc;
    logic [4*YW-1:0] e;
    int sent_rows, got, cyc;
    logic v, ordy;

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_row = '0;
    repeat (3) @(negedge clk);
    chk("rst_rowidx", row_idx, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_tile", (out_tile == '0), 1);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", in_ready, 1);

    // All ones, back to back
    fill(1);
    run_rows("ones", 0, 3, 1'b1);
    chk("ones_valid", out_valid, 1);
    check_y("ones", 9, -3, -3, 1);
    step(1'b0, '0, 1'b1, acc);
    chk("ones_drain", out_valid, 0);

    // Single non-zero m[1][1]; idle cycle with toggling data mid-tile
    fill(0); mtx[1][1] = 5;
    run_rows("m11", 0, 1, 1'b1);
    step(1'b0, 64'hDEAD_BEEF_1234_5678, 1'b1, acc);
    chk("m11_hold_rowidx", row_idx, 2);
    chk("m11_busy", busy, 1);
    run_rows("m11", 2, 3, 1'b1);
    chk("m11_rowidx_wrap", row_idx, 0);
    check_y("m11", 5, 5, 5, 5);
    step(1'b0, '0, 1'b1, acc);

    // Most negative inputs
    fill(-32768);
    run_rows("neg", 0, 3, 1'b1);
    check_y("neg", -294912, 98304, 98304, -32768);
    step(1'b0, '0, 1'b1, acc);

    // Stall: tile A held, tile B rows 0..2 go in, row 3 waits for out_ready
    fill(1);
    run_rows("stA", 0, 3, 1'b0);
    fill(0); mtx[1][1] = 5;
    run_rows("stB", 0, 2, 1'b0);
    repeat (2) begin
      step(1'b1, rowpack(3), 1'b0, acc);
      chk("st_blocked", acc, 0);
      chk("st_hold_valid", out_valid, 1);
      check_y("st_holdA", 9, -3, -3, 1);
    end
    step(1'b1, rowpack(3), 1'b1, acc);
    chk("st_accept", acc, 1);
    chk("st_valid_kept", out_valid, 1);
    check_y("st_B", 5, 5, 5, 5);
    step(1'b0, '0, 1'b1, acc);
    chk("st_drain", out_valid, 0);

    // clr after 2 rows with a stalled output
    fill(1);
    run_rows("clrA", 0, 3, 1'b0);
    run_rows("clrP", 0, 1, 1'b0);
    clr = 1'b1;
    step(1'b1, rowpack(2), 1'b0, acc);
    clr = 1'b0;
    chk("clr_valid", out_valid, 0);
    chk("clr_rowidx", row_idx, 0);
    chk("clr_busy", busy, 0);
    fill(-32768);
    run_rows("clrN", 0, 3, 1'b1);
    check_y("clrN", -294912, 98304, 98304, -32768);
    step(1'b0, '0, 1'b1, acc);

    // Async reset after 2 rows with a stalled output
    fill(1);
    run_rows("rstA", 0, 3, 1'b0);
    run_rows("rstP", 0, 1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_rowidx", row_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill(0); mtx[1][1] = 5;
    run_rows("rstN", 0, 3, 1'b1);
    check_y("rstN", 5, 5, 5, 5);
    step(1'b0, '0, 1'b1, acc);

    // Eight tiles with random input gaps and random backpressure
    for (int t = 0; t < 8; t++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          rt[t][r][c] = int'($urandom_range(0, 65535)) - 32768;
    sent_rows = 0; got = 0; cyc = 0;
    while (got < 8 && cyc < 3000) begin
      ordy = ($urandom_range(0, 3) != 0);
      if (out_valid && ordy) begin
        if (exp_q.size() == 0) begin
          chk("rand_unexpected_tile", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rand_y00", yf(out_tile, 0), yf(e, 0));
          chk("rand_y01", yf(out_tile, 1), yf(e, 1));
          chk("rand_y10", yf(out_tile, 2), yf(e, 2));
          chk("rand_y11", yf(out_tile, 3), yf(e, 3));
        end
        got++;
      end
      v = (sent_rows < 32) && ($urandom_range(0, 2) != 0);
      step(v, (sent_rows < 32) ? rowpack_rt(sent_rows / 4, sent_rows % 4) : '0,
           ordy, acc);
      if (acc) begin
        if (sent_rows % 4 == 3) exp_q.push_back(golden(sent_rows / 4));
        sent_rows++;
      end
      cyc++;
    end
    chk("rand_tiles", got, 8);
    chk("rand_rows", sent_rows, 32);
    chk("rand_leftover", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
